// File: rtl/input_window_streamer_pkg.sv
// Shared definitions for the input window streamer.
// Holds the controller state encoding and the helpers that derive the
// lane-select width and the element-address width from the spad geometry.
package input_window_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bits needed to select one element inside a spad word.
    function automatic int lane_bits(input int spad_n);
        return $clog2(spad_n);
    endfunction

    // Width of an element address: word address plus lane select.
    function automatic int elem_addr_width(input int addr_width, input int spad_n);
        return addr_width + lane_bits(spad_n);
    endfunction

endpackage

// File: rtl/input_window_streamer_if.sv
// Bundle of the streamer's control, config, spad-read and vector-output signals.
// master: the surrounding system (drives start/config/read data/ready).
// slave : the streamer itself.
interface input_window_streamer_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8,
    parameter int DIM_WIDTH       = 8,
    parameter int ROWS            = 4
);
    logic                         i_start;
    logic                         i_clear;
    logic [DIM_WIDTH-1:0]         i_i_size;
    logic [DIM_WIDTH-1:0]         i_i_c_size;
    logic [DIM_WIDTH-1:0]         i_k_size;
    logic [DIM_WIDTH-1:0]         i_stride;
    logic [DIM_WIDTH-1:0]         i_pad;
    logic [DIM_WIDTH-1:0]         i_o_size;
    logic [ADDR_WIDTH-1:0]        i_base_addr;
    logic                         o_spad_read_en;
    logic [ADDR_WIDTH-1:0]        o_spad_read_addr;
    logic [SPAD_DATA_WIDTH-1:0]   i_spad_data;
    logic [ROWS*DATA_WIDTH-1:0]   o_data;
    logic [ROWS-1:0]              o_data_valid;
    logic                         o_valid;
    logic                         i_ready;
    logic                         o_last_tap;
    logic                         o_busy;
    logic                         o_done;

    modport master (
        output i_start, i_clear, i_i_size, i_i_c_size, i_k_size, i_stride, i_pad,
               i_o_size, i_base_addr, i_spad_data, i_ready,
        input  o_spad_read_en, o_spad_read_addr, o_data, o_data_valid, o_valid,
               o_last_tap, o_busy, o_done
    );

    modport slave (
        input  i_start, i_clear, i_i_size, i_i_c_size, i_k_size, i_stride, i_pad,
               i_o_size, i_base_addr, i_spad_data, i_ready,
        output o_spad_read_en, o_spad_read_addr, o_data, o_data_valid, o_valid,
               o_last_tap, o_busy, o_done
    );

endinterface

// File: rtl/input_window_streamer_window_coord_gen.sv
// Window coordinate generator.
// Owns the channel/kx/ky tap counters and the pixel-group position, and a
// row walker that steps through the ROWS pixels of the current group while
// the controller fetches. For the walker's current pixel it reports whether
// the element is padding, whether the pixel lies past the output plane, and
// the spad word/lane that holds the element.
// Ports: clk/rst (async, high), clear (sync abort), start (latch config and
// zero counters), step_row (advance walker one pixel), next_vec (vector
// accepted: advance tap, rewind walker or move to next group), config fields,
// row_pad/row_inval flags, word_addr/lane, last_tap, last_vec.
module window_coord_gen
    import input_window_streamer_pkg::*;
#(
    parameter int  ADDR_WIDTH = 8,
    parameter int  DIM_WIDTH  = 8,
    parameter int  SPAD_N     = 8,
    localparam int LB         = lane_bits(SPAD_N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  step_row,
    input  logic                  next_vec,
    input  logic [DIM_WIDTH-1:0]  i_size,
    input  logic [DIM_WIDTH-1:0]  c_size,
    input  logic [DIM_WIDTH-1:0]  k_size,
    input  logic [DIM_WIDTH-1:0]  stride,
    input  logic [DIM_WIDTH-1:0]  pad,
    input  logic [DIM_WIDTH-1:0]  o_size,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  row_pad,
    output logic                  row_inval,
    output logic [ADDR_WIDTH-1:0] word_addr,
    output logic [LB-1:0]         lane,
    output logic                  last_tap,
    output logic                  last_vec
);
    localparam int CW = DIM_WIDTH + 2;
    localparam int EW = elem_addr_width(ADDR_WIDTH, SPAD_N);
    localparam int PW = 2 * DIM_WIDTH + 1;

    logic [DIM_WIDTH-1:0]  size_r, csz_r, ksz_r, str_r, pad_r, osz_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [DIM_WIDTH-1:0]  c_r, kx_r, ky_r;
    logic [PW-1:0]         grp_p_r, wk_p_r;
    logic [DIM_WIDTH-1:0]  grp_oy_r, grp_ox_r, wk_oy_r, wk_ox_r;

    logic                  c_last_s, kx_last_s, ky_last_s;
    logic [PW-1:0]         area_s;
    logic [CW-1:0]         iy_s, ix_s;
    logic [EW-1:0]         elem_s;

    assign c_last_s  = (c_r  == csz_r - DIM_WIDTH'(1'b1));
    assign kx_last_s = (kx_r == ksz_r - DIM_WIDTH'(1'b1));
    assign ky_last_s = (ky_r == ksz_r - DIM_WIDTH'(1'b1));
    assign last_tap  = c_last_s && kx_last_s && ky_last_s;

    // Walker sits ROWS pixels past the group base once the group is fetched,
    // so it marks the final group when it has run off the output plane.
    assign area_s    = PW'(osz_r) * PW'(osz_r);
    assign row_inval = (wk_p_r >= area_s);
    assign last_vec  = last_tap && row_inval;

    // Two's-complement coordinates; a set top bit means negative.
    assign iy_s = CW'(wk_oy_r) * CW'(str_r) + CW'(ky_r) - CW'(pad_r);
    assign ix_s = CW'(wk_ox_r) * CW'(str_r) + CW'(kx_r) - CW'(pad_r);

    assign row_pad = iy_s[CW-1] || (iy_s >= CW'(size_r)) ||
                     ix_s[CW-1] || (ix_s >= CW'(size_r));

    // Only meaningful for in-range rows, where iy/ix fit in DIM_WIDTH bits.
    assign elem_s = (EW'(base_r) << LB)
                  + (EW'(iy_s[DIM_WIDTH-1:0]) * EW'(size_r) + EW'(ix_s[DIM_WIDTH-1:0])) * EW'(csz_r)
                  + EW'(c_r);

    assign word_addr = elem_s[EW-1:LB];
    assign lane      = elem_s[LB-1:0];

    // Config latch, tap counters, group base and row walker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_r <= '0; csz_r <= '0; ksz_r <= '0; str_r <= '0; pad_r <= '0; osz_r <= '0;
            base_r <= '0;
            c_r <= '0; kx_r <= '0; ky_r <= '0;
            grp_p_r <= '0; grp_oy_r <= '0; grp_ox_r <= '0;
            wk_p_r <= '0; wk_oy_r <= '0; wk_ox_r <= '0;
        end else if (clear) begin
            size_r <= '0; csz_r <= '0; ksz_r <= '0; str_r <= '0; pad_r <= '0; osz_r <= '0;
            base_r <= '0;
            c_r <= '0; kx_r <= '0; ky_r <= '0;
            grp_p_r <= '0; grp_oy_r <= '0; grp_ox_r <= '0;
            wk_p_r <= '0; wk_oy_r <= '0; wk_ox_r <= '0;
        end else if (start) begin
            size_r <= i_size; csz_r <= c_size; ksz_r <= k_size;
            str_r <= stride; pad_r <= pad; osz_r <= o_size;
            base_r <= base_addr;
            c_r <= '0; kx_r <= '0; ky_r <= '0;
            grp_p_r <= '0; grp_oy_r <= '0; grp_ox_r <= '0;
            wk_p_r <= '0; wk_oy_r <= '0; wk_ox_r <= '0;
        end else if (step_row) begin
            wk_p_r <= wk_p_r + PW'(1'b1);
            if (wk_ox_r == osz_r - DIM_WIDTH'(1'b1)) begin
                wk_ox_r <= '0;
                wk_oy_r <= wk_oy_r + DIM_WIDTH'(1'b1);
            end else begin
                wk_ox_r <= wk_ox_r + DIM_WIDTH'(1'b1);
            end
        end else if (next_vec) begin
            if (c_last_s) begin
                c_r <= '0;
                if (kx_last_s) begin
                    kx_r <= '0;
                    ky_r <= ky_last_s ? '0 : ky_r + DIM_WIDTH'(1'b1);
                end else begin
                    kx_r <= kx_r + DIM_WIDTH'(1'b1);
                end
            end else begin
                c_r <= c_r + DIM_WIDTH'(1'b1);
            end
            // New group starts where the walker stopped; otherwise rewind.
            if (last_tap) begin
                grp_p_r <= wk_p_r; grp_oy_r <= wk_oy_r; grp_ox_r <= wk_ox_r;
            end else begin
                wk_p_r <= grp_p_r; wk_oy_r <= grp_oy_r; wk_ox_r <= grp_ox_r;
            end
        end
    end

endmodule

// File: rtl/input_window_streamer.sv
// Input window streamer: reads convolution input windows out of the input
// scratchpad and presents one ROWS-wide vector per kernel tap, per group of
// ROWS consecutive output pixels, with valid/ready backpressure and hardware
// zero padding.
// Ports: i_clk, i_rst (async, active high) and the slave side of
// input_window_streamer_if (start/clear, config, spad read port, vector
// output with valid/ready, last_tap, busy, done).
module input_window_streamer
    import input_window_streamer_pkg::*;
#(
    parameter int  DATA_WIDTH      = 8,
    parameter int  SPAD_DATA_WIDTH = 64,
    parameter int  SPAD_N          = SPAD_DATA_WIDTH / DATA_WIDTH,
    parameter int  ADDR_WIDTH      = 8,
    parameter int  DIM_WIDTH       = 8,
    parameter int  ROWS            = 4,
    localparam int LB              = lane_bits(SPAD_N),
    localparam int RW              = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input logic                    i_clk,
    input logic                    i_rst,
    input_window_streamer_if.slave bus
);
    state_t                              state_r;
    logic [RW-1:0]                       row_r;
    logic                                busy_r, done_r, valid_r, last_tap_r;

    logic                                p1_cap_r, p1_rd_r, p1_inval_r;
    logic [RW-1:0]                       p1_row_r;
    logic [LB-1:0]                       p1_lane_r;
    logic [ROWS-1:0][DATA_WIDTH-1:0]     data_r;
    logic [ROWS-1:0]                     mask_r;

    logic                                row_pad_s, row_inval_s, last_tap_s, last_vec_s;
    logic [ADDR_WIDTH-1:0]               word_s;
    logic [LB-1:0]                       lane_s;
    logic                                start_s, accept_s, fetch_s, rd_s, zero_cfg_s;
    logic [SPAD_N-1:0][DATA_WIDTH-1:0]   spad_lanes_s;

    assign start_s    = (state_r == ST_IDLE) && bus.i_start;
    assign accept_s   = (state_r == ST_OUT) && bus.i_ready;
    assign fetch_s    = (state_r == ST_FETCH);
    assign rd_s       = fetch_s && !row_pad_s && !row_inval_s;
    assign zero_cfg_s = (bus.i_o_size == {DIM_WIDTH{1'b0}}) ||
                        (bus.i_k_size == {DIM_WIDTH{1'b0}}) ||
                        (bus.i_i_c_size == {DIM_WIDTH{1'b0}});
    assign spad_lanes_s = bus.i_spad_data;

    assign bus.o_spad_read_en   = rd_s;
    assign bus.o_spad_read_addr = rd_s ? word_s : {ADDR_WIDTH{1'b0}};
    assign bus.o_data           = data_r;
    assign bus.o_data_valid     = mask_r;
    assign bus.o_valid          = valid_r;
    assign bus.o_last_tap       = last_tap_r;
    assign bus.o_busy           = busy_r;
    assign bus.o_done           = done_r;

    window_coord_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH),
        .SPAD_N     (SPAD_N)
    ) u_coord (
        .clk       (i_clk),
        .rst       (i_rst),
        .clear     (bus.i_clear),
        .start     (start_s),
        .step_row  (fetch_s),
        .next_vec  (accept_s),
        .i_size    (bus.i_i_size),
        .c_size    (bus.i_i_c_size),
        .k_size    (bus.i_k_size),
        .stride    (bus.i_stride),
        .pad       (bus.i_pad),
        .o_size    (bus.i_o_size),
        .base_addr (bus.i_base_addr),
        .row_pad   (row_pad_s),
        .row_inval (row_inval_s),
        .word_addr (word_s),
        .lane      (lane_s),
        .last_tap  (last_tap_s),
        .last_vec  (last_vec_s)
    );

    // Controller FSM with registered valid/last_tap/busy/done.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE; row_r <= '0;
            busy_r <= 1'b0; done_r <= 1'b0; valid_r <= 1'b0; last_tap_r <= 1'b0;
        end else if (bus.i_clear) begin
            state_r <= ST_IDLE; row_r <= '0;
            busy_r <= 1'b0; done_r <= 1'b0; valid_r <= 1'b0; last_tap_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        row_r <= '0;
                        if (zero_cfg_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_FETCH;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (row_r == RW'(ROWS - 1)) begin
                        row_r   <= '0;
                        state_r <= ST_DRAIN;
                    end else begin
                        row_r <= row_r + RW'(1'b1);
                    end
                end
                ST_DRAIN: begin
                    state_r    <= ST_OUT;
                    valid_r    <= 1'b1;
                    last_tap_r <= last_tap_s;
                end
                ST_OUT: begin
                    if (bus.i_ready) begin
                        valid_r    <= 1'b0;
                        last_tap_r <= 1'b0;
                        if (last_vec_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE; row_r <= '0;
                    busy_r <= 1'b0; done_r <= 1'b0; valid_r <= 1'b0; last_tap_r <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline: row/lane/flags follow each read by one cycle, then the
    // returned lane (or a zero for pad/invalid rows) lands in the output row.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            p1_cap_r <= 1'b0; p1_rd_r <= 1'b0; p1_inval_r <= 1'b0;
            p1_row_r <= '0; p1_lane_r <= '0;
            data_r <= '0; mask_r <= '0;
        end else if (bus.i_clear) begin
            p1_cap_r <= 1'b0; p1_rd_r <= 1'b0; p1_inval_r <= 1'b0;
            p1_row_r <= '0; p1_lane_r <= '0;
            data_r <= '0; mask_r <= '0;
        end else begin
            p1_cap_r   <= fetch_s;
            p1_rd_r    <= rd_s;
            p1_inval_r <= row_inval_s;
            p1_row_r   <= row_r;
            p1_lane_r  <= lane_s;
            if (p1_cap_r) begin
                data_r[p1_row_r] <= p1_rd_r ? spad_lanes_s[p1_lane_r] : {DATA_WIDTH{1'b0}};
                mask_r[p1_row_r] <= !p1_inval_r;
            end
        end
    end

endmodule

// File: tb/tb_input_window_streamer.sv
module tb_input_window_streamer;

    localparam int ROWS = 4;

    typedef struct {
        int          size, ch, k, s, pd, o, base, nvec;
        logic [31:0] first_data;
        logic [3:0]  first_mask;
        logic [31:0] last_data;
        logic [3:0]  last_mask;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        logic        last;
        int          nrd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    exp_t exp_q[$];
    int   exp_rd[$];
    int   got_rd[$];
    vec_t tbl[5];

    input_window_streamer_if #(.DATA_WIDTH(8), .SPAD_DATA_WIDTH(64), .ADDR_WIDTH(8),
                               .DIM_WIDTH(8), .ROWS(ROWS)) bus ();

    input_window_streamer dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Spad memory: element e holds (e+1) mod 256; unread cycles carry noise.
    function automatic logic [63:0] mem_word(input logic [7:0] a);
        logic [63:0] w;
        int v;
        for (int l = 0; l < 8; l++) begin
            v = int'(a) * 8 + l + 1;
            w[l*8 +: 8] = v[7:0];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (bus.o_spad_read_en) bus.i_spad_data <= mem_word(bus.o_spad_read_addr);
        else                    bus.i_spad_data <= {$urandom, $urandom};
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference: enumerate groups/taps/channels/rows directly from the window definition.
    task automatic build_model(input vec_t c);
        int p, oy, ox, iy, ix, elem, v;
        exp_t e;
        exp_q.delete();
        exp_rd.delete();
        if (c.o == 0 || c.k == 0 || c.ch == 0) return;
        for (int g = 0; g < (c.o * c.o + ROWS - 1) / ROWS; g++)
            for (int ky = 0; ky < c.k; ky++)
                for (int kx = 0; kx < c.k; kx++)
                    for (int ch = 0; ch < c.ch; ch++) begin
                        e.data = 32'd0; e.mask = 4'd0; e.nrd = 0;
                        e.last = (ch == c.ch - 1) && (kx == c.k - 1) && (ky == c.k - 1);
                        for (int r = 0; r < ROWS; r++) begin
                            p = g * ROWS + r;
                            if (p < c.o * c.o) begin
                                oy = p / c.o; ox = p % c.o;
                                iy = oy * c.s + ky - c.pd;
                                ix = ox * c.s + kx - c.pd;
                                e.mask[r] = 1'b1;
                                if (iy >= 0 && iy < c.size && ix >= 0 && ix < c.size) begin
                                    elem = (c.base * 8 + (iy * c.size + ix) * c.ch + ch) % 2048;
                                    exp_rd.push_back(elem / 8);
                                    e.nrd++;
                                    v = elem + 1;
                                    e.data[r*8 +: 8] = v[7:0];
                                end
                            end
                        end
                        exp_q.push_back(e);
                    end
    endtask

    task automatic drive_cfg(input vec_t c);
        bus.i_i_size = 8'(c.size); bus.i_i_c_size = 8'(c.ch); bus.i_k_size = 8'(c.k);
        bus.i_stride = 8'(c.s);    bus.i_pad = 8'(c.pd);      bus.i_o_size = 8'(c.o);
        bus.i_base_addr = 8'(c.base);
    endtask

    // mode 0: always ready, 1: random ready, 2: five-cycle stall at vector 3.
    task automatic run_job(input vec_t c, input int mode, input bit use_tbl);
        int n = 0, vi = 0, rdc = 0, stall = 0, mism = 0;
        bit done_seen = 0, first_seen = 0, held = 0, ready;
        logic [63:0] snap = 64'd0;
        exp_t fv, lv;
        build_model(c);
        got_rd.delete();
        @(negedge clk);
        drive_cfg(c);
        bus.i_start = 1'b1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        while (!done_seen && n < 20000) begin
            n++;
            ready = 1'b1;
            if (bus.o_spad_read_en) begin
                got_rd.push_back(int'(bus.o_spad_read_addr));
                rdc++;
            end
            if (bus.o_done) done_seen = 1;
            else            check("busy", 64'(bus.o_busy), 64'd1);
            if (bus.o_valid) begin
                if (!first_seen) begin
                    first_seen = 1;
                    check("first_latency", 64'(n), 64'(ROWS + 2));
                end
                check("no_read_in_out", 64'(bus.o_spad_read_en), 64'd0);
                if (held) check("hold_stable", 64'({bus.o_last_tap, bus.o_data_valid, bus.o_data}), snap);
                if (mode == 1) ready = ($urandom_range(0, 2) != 0);
                else if (mode == 2 && vi == 3 && stall < 5) begin
                    ready = 1'b0;
                    stall++;
                end
                snap = 64'({bus.o_last_tap, bus.o_data_valid, bus.o_data});
                held = !ready;
                if (ready) begin
                    if (vi < exp_q.size()) begin
                        check("vec_data", 64'(bus.o_data), 64'(exp_q[vi].data));
                        check("vec_mask", 64'(bus.o_data_valid), 64'(exp_q[vi].mask));
                        check("vec_last", 64'(bus.o_last_tap), 64'(exp_q[vi].last));
                        check("vec_reads", 64'(rdc), 64'(exp_q[vi].nrd));
                    end else begin
                        check("extra_vec", 64'(vi), 64'(exp_q.size()));
                    end
                    if (vi == 0) begin
                        fv.data = bus.o_data; fv.mask = bus.o_data_valid;
                    end
                    lv.data = bus.o_data; lv.mask = bus.o_data_valid; lv.last = bus.o_last_tap;
                    vi++;
                    rdc = 0;
                end
            end else begin
                held = 0;
            end
            bus.i_ready = ready;
            @(negedge clk);
        end
        check("done_seen", 64'(done_seen), 64'd1);
        check("vec_count", 64'(vi), 64'(exp_q.size()));
        check("done_pulse", 64'(bus.o_done), 64'd0);
        check("idle_busy", 64'(bus.o_busy), 64'd0);
        check("read_count", 64'(got_rd.size()), 64'(exp_rd.size()));
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
            if (got_rd[i] != exp_rd[i]) mism++;
        check("read_addrs", 64'(mism), 64'd0);
        if (mode == 2) check("stall_len", 64'(stall), 64'd5);
        if (exp_q.size() == 0) check("degenerate_done_cycle", 64'(n), 64'd1);
        if (use_tbl) begin
            check("tbl_count", 64'(vi), 64'(c.nvec));
            if (c.nvec > 0) begin
                check("tbl_first_data", 64'(fv.data), 64'(c.first_data));
                check("tbl_first_mask", 64'(fv.mask), 64'(c.first_mask));
                check("tbl_last_data", 64'(lv.data), 64'(c.last_data));
                check("tbl_last_mask", 64'(lv.mask), 64'(c.last_mask));
                check("tbl_last_tap", 64'(lv.last), 64'd1);
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.o_valid) ok = 1;
        end
    endtask

    initial begin
        vec_t rc;
        bit ok, seen;
        //            size ch k s pd o base nvec first_data    fm     last_data     lm
        tbl[0] = '{4, 1, 3, 1, 0, 2, 0, 9, 32'h06050201, 4'hF, 32'h100F0C0B, 4'hF};
        tbl[1] = '{2, 1, 3, 1, 1, 2, 0, 9, 32'h01000000, 4'hF, 32'h00000004, 4'hF};
        tbl[2] = '{5, 1, 1, 2, 0, 3, 0, 3, 32'h0B050301, 4'hF, 32'h00000019, 4'h1};
        tbl[3] = '{2, 3, 1, 1, 0, 2, 1, 3, 32'h120F0C09, 4'hF, 32'h14110E0B, 4'hF};
        tbl[4] = '{4, 1, 3, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 4'h0};

        bus.i_start = 1'b0; bus.i_clear = 1'b0; bus.i_ready = 1'b0;
        drive_cfg(tbl[0]);
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_data", 64'({bus.o_data, bus.o_data_valid}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_done", 64'({bus.o_busy, bus.o_done, bus.o_last_tap, bus.o_spad_read_en}), 64'd0);

        for (int t = 0; t < 5; t++) run_job(tbl[t], 0, 1'b1);

        // Backpressure at vector 3.
        run_job(tbl[0], 2, 1'b1);

        // Randomized windows against the reference model.
        for (int t = 0; t < 8; t++) begin
            rc.size = $urandom_range(1, 6); rc.ch = $urandom_range(1, 3);
            rc.s = $urandom_range(1, 2);    rc.pd = $urandom_range(0, 1);
            rc.k = $urandom_range(1, 3);
            if (rc.k > rc.size + 2 * rc.pd) rc.k = rc.size + 2 * rc.pd;
            rc.o = (rc.size + 2 * rc.pd - rc.k) / rc.s + 1;
            rc.base = $urandom_range(0, 255);
            rc.nvec = 0;
            run_job(rc, 1, 1'b0);
        end

        // Clear during FETCH: back to IDLE, no done, in-flight data dropped.
        @(negedge clk);
        drive_cfg(tbl[0]);
        bus.i_start = 1'b1; bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
        check("clr_busy", 64'(bus.o_busy), 64'd0);
        check("clr_read", 64'(bus.o_spad_read_en), 64'd0);
        seen = 0;
        repeat (10) begin
            if (bus.o_done || bus.o_valid || bus.o_spad_read_en) seen = 1;
            @(negedge clk);
        end
        check("clr_quiet", 64'(seen), 64'd0);
        check("clr_mask", 64'(bus.o_data_valid), 64'd0);

        // Asynchronous reset while holding a vector.
        drive_cfg(tbl[0]);
        bus.i_start = 1'b1; bus.i_ready = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_valid(ok);
        check("rst_out_reached", 64'(ok), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", 64'(bus.o_valid), 64'd0);
        check("arst_busy", 64'(bus.o_busy), 64'd0);
        check("arst_data", 64'({bus.o_data, bus.o_data_valid}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_job(tbl[0], 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_window_streamer.md
Name: input_window_streamer

Overview:
Parametrised next-generation input router front end. It streams convolution input windows out of the input scratchpad for a configurable kernel size, stride, zero-padding and channel count, and emits one ROWS-wide vector per kernel tap for a group of ROWS consecutive output pixels. It sits between the input spad read port and the PE array row inputs. A valid/ready handshake gives it backpressure, and it generates padding zeros in hardware.

Parameters:
DATA_WIDTH, 8, element width
SPAD_DATA_WIDTH, 64, spad word width
SPAD_N, SPAD_DATA_WIDTH/DATA_WIDTH, elements per spad word; must be a power of 2
ADDR_WIDTH, 8, spad word address width
DIM_WIDTH, 8, width of size/stride/pad/channel config fields
ROWS, 4, output rows (pixels) per vector

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_start  in  1  start pulse; config is latched on this cycle; ignored while o_busy
i_clear  in  1  synchronous abort to IDLE; no o_done pulse
i_i_size  in  DIM_WIDTH  input height = width
i_i_c_size  in  DIM_WIDTH  channel count C
i_k_size  in  DIM_WIDTH  kernel height = width K
i_stride  in  DIM_WIDTH  stride S (>=1)
i_pad  in  DIM_WIDTH  zero padding P
i_o_size  in  DIM_WIDTH  output height = width O, computed upstream
i_base_addr  in  ADDR_WIDTH  spad word address of element 0
o_spad_read_en  out  1  spad read strobe
o_spad_read_addr  out  ADDR_WIDTH  spad word address
i_spad_data  in  SPAD_DATA_WIDTH  read data, valid exactly 1 cycle after o_spad_read_en
o_data  out  ROWS*DATA_WIDTH  per-row element
o_data_valid  out  ROWS  per-row valid mask
o_valid  out  1  vector available
i_ready  in  1  consumer accepts when o_valid & i_ready
o_last_tap  out  1  vector is the final tap of its pixel group
o_busy  out  1  high from the cycle after start until o_done
o_done  out  1  1-cycle pulse after the final accept

Behaviour:
- Reset/clear: all outputs 0, FSM in IDLE, all counters 0.
- Loop order (innermost to outermost): channel c, then kx, then ky, then pixel group g. Group g covers pixels p = g*ROWS + r, r in 0..ROWS-1, raster order oy = p / O, ox = p % O. Track oy/ox with incrementing counters; no dividers.
- Coordinates per row: iy = oy*S + ky - P, ix = ox*S + kx - P, computed signed at DIM_WIDTH+2 bits.
- Padding: iy or ix outside [0, i_size-1] makes the element a pad. A pad issues no spad read and its o_data lane is 0 with o_data_valid set.
- Out-of-range rows: p >= O*O. No read is issued, o_data lane is 0 and o_data_valid is 0.
- Address arithmetic:
  - elem = (i_base_addr << log2 SPAD_N) + (iy*i_size + ix)*C + c, truncated to ADDR_WIDTH+log2 SPAD_N bits.
  - word = elem >> log2 SPAD_N.
  - lane = elem[log2 SPAD_N - 1:0]; lane 0 is the LSB slice.
- FSM states and transitions:
  - IDLE: on i_start, go to FETCH. If O, K or C is 0, go to DONE instead.
  - FETCH: lasts ROWS cycles; row r is handled in cycle r (read or skip). Row index, lane and pad/invalid flags are delayed 1 cycle alongside each read. Capture into the output register happens 1 cycle after issue.
  - DRAIN: 1 cycle for the final capture. o_valid rises the following cycle, so first vector o_valid = start + ROWS + 2.
  - OUT: o_valid held; o_data, o_data_valid and o_last_tap stay stable until accepted. On accept, advance the loop counters and go to FETCH, or to DONE after the last tap of the last group.
  - DONE: o_done = 1 for one cycle, then IDLE.
- No spad reads are issued while in OUT (backpressure stalls fetch).
- o_last_tap = 1 when c = C-1, kx = K-1 and ky = K-1.
- Total vectors = ceil(O*O/ROWS) * K*K*C.
- i_rst asserted mid-operation returns immediately to the reset state. i_clear mid-operation returns to IDLE next cycle, and any in-flight read data is discarded.

Decomposition:
- Shared package: fsm state enum (IDLE, FETCH, DRAIN, OUT, DONE), the LANE_BITS = $clog2(SPAD_N) helper, and the elem-address width constant.
- One sub-module, window_coord_gen, owns the c/kx/ky/group/oy/ox counters and outputs iy, ix, pad/invalid flags and the element address for the current row.
- The top level holds the FSM, the read pipeline and the output register.

Test Plan:
- Basic window: size 4, C=1, K=3, S=1, P=0, O=2, spad element value = elem+1. First vector {1,2,5,6} with mask 1111, last vector {11,12,15,16} with o_last_tap=1. 9 vectors, then o_done.
- Padding: size 2, C=1, K=3, S=1, P=1, O=2. Tap (0,0) vector {0,0,0,1}, mask 1111. Tap (2,2) vector {4,0,0,0}. No read is issued for pad rows.
- Partial group and stride: size 5, C=1, K=1, S=2, O=3. 3 vectors; the last has mask 0001 and data {25,0,0,0}.
- Channels crossing a word: size 2, C=3, K=1, O=2, base 1. Row 2 channel 2 is elem 16, so it reads word 2, lane 0, value 17. Row 3 channel 0 is elem 17, so word 2, lane 1, value 18.
- Backpressure: hold i_ready low for 5 cycles at vector 3. o_data is stable, o_spad_read_en stays 0, and the total vector count is unchanged.
- Abort: i_clear in FETCH gives IDLE next cycle with no o_done. Async i_rst in OUT clears o_valid without waiting for a clock edge. A following i_start produces the basic-window sequence.
